// File: rtl/qe_speed_if.sv
`default_nettype none
// -----------------------------------------------------------------------------
// qe_speed_if : config/status bundle between channel register bank and speed unit
// Revision    : 1.0
// -----------------------------------------------------------------------------
interface qe_speed_if #(
    parameter int COUNT_WIDTH = 24
);
    logic                   enable;
    logic                   qe_a;
    logic [2:0]             filter_log2;
    logic [COUNT_WIDTH-1:0] count_limit;
    logic [COUNT_WIDTH-1:0] speed_value;
    logic                   speed_valid;
    logic                   stalled;
    logic                   busy;

    modport master (
        output enable, qe_a, filter_log2, count_limit,
        input  speed_value, speed_valid, stalled, busy
    );

    modport slave (
        input  enable, qe_a, filter_log2, count_limit,
        output speed_value, speed_valid, stalled, busy
    );
endinterface
`default_nettype wire

// File: rtl/qe_speed_measure_unit.sv
`default_nettype none
// -----------------------------------------------------------------------------
// qe_speed_measure_unit : averaged QE A-channel high-pulse width with stall detect
// Revision              : 1.0
// -----------------------------------------------------------------------------
module qe_speed_measure_unit #(
    parameter int COUNT_WIDTH      = 24,
    parameter int MAX_LOG2_SAMPLES = 4
) (
    input  wire logic clk,
    input  wire logic reset,
    qe_speed_if.slave bus
);
    localparam int              ACC_WIDTH = COUNT_WIDTH + MAX_LOG2_SAMPLES;
    localparam int              SL_WIDTH  = MAX_LOG2_SAMPLES + 1;
    localparam logic [2:0]      MAX_K     = 3'(MAX_LOG2_SAMPLES);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_INIT      = 3'd1,
        S_WAIT_RISE = 3'd2,
        S_MEASURE   = 3'd3,
        S_ACCUM     = 3'd4,
        S_DIVIDE    = 3'd5,
        S_LOAD      = 3'd6,
        S_STALL     = 3'd7
    } state_t;

    state_t                 state_q, state_d;
    logic [2:0]             k_q, k_d;
    logic [COUNT_WIDTH-1:0] lim_q, lim_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic [COUNT_WIDTH-1:0] gap_q, gap_d;
    logic [COUNT_WIDTH-1:0] avg_q, avg_d;
    logic [COUNT_WIDTH-1:0] speed_value_q, speed_value_d;
    logic [SL_WIDTH-1:0]    samples_left_q, samples_left_d;
    logic [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic                   armed_q, armed_d;
    logic                   stalled_q, stalled_d;

    logic [COUNT_WIDTH-1:0] w_count_inc;
    logic [COUNT_WIDTH-1:0] w_gap_inc;
    logic [2:0]             w_k_clamped;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            k_q            <= '0;
            lim_q          <= '0;
            count_q        <= '0;
            gap_q          <= '0;
            avg_q          <= '0;
            speed_value_q  <= '0;
            samples_left_q <= '0;
            acc_q          <= '0;
            armed_q        <= 1'b0;
            stalled_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            k_q            <= k_d;
            lim_q          <= lim_d;
            count_q        <= count_d;
            gap_q          <= gap_d;
            avg_q          <= avg_d;
            speed_value_q  <= speed_value_d;
            samples_left_q <= samples_left_d;
            acc_q          <= acc_d;
            armed_q        <= armed_d;
            stalled_q      <= stalled_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        k_d            = k_q;
        lim_d          = lim_q;
        count_d        = count_q;
        gap_d          = gap_q;
        avg_d          = avg_q;
        speed_value_d  = speed_value_q;
        samples_left_d = samples_left_q;
        acc_d          = acc_q;
        armed_d        = armed_q;
        stalled_d      = stalled_q;
        w_count_inc    = count_q + COUNT_WIDTH'(1);
        w_gap_inc      = gap_q + COUNT_WIDTH'(1);
        w_k_clamped    = (bus.filter_log2 > MAX_K) ? MAX_K : bus.filter_log2;

        case (state_q)
            S_IDLE: begin
                if (bus.enable) state_d = S_INIT;
            end
            S_INIT: begin
                k_d            = w_k_clamped;
                lim_d          = (bus.count_limit == '0) ? '1 : bus.count_limit;
                samples_left_d = SL_WIDTH'(1) << w_k_clamped;
                acc_d          = '0;
                count_d        = '0;
                gap_d          = '0;
                armed_d        = 1'b0;
                state_d        = S_WAIT_RISE;
            end
            S_WAIT_RISE: begin
                // A high level is only a valid edge once A has been seen low
                if (bus.qe_a) begin
                    if (armed_q) begin
                        state_d = S_MEASURE;
                        count_d = COUNT_WIDTH'(1);
                        gap_d   = '0;
                        armed_d = 1'b0;
                    end
                end else begin
                    armed_d = 1'b1;
                    gap_d   = w_gap_inc;
                    if (w_gap_inc >= lim_q - COUNT_WIDTH'(1)) state_d = S_STALL;
                end
            end
            S_MEASURE: begin
                if (bus.qe_a) begin
                    count_d = w_count_inc;
                    if (w_count_inc >= lim_q) state_d = S_STALL;
                end else begin
                    state_d = S_ACCUM;
                end
            end
            S_ACCUM: begin
                acc_d          = acc_q + ACC_WIDTH'(count_q);
                samples_left_d = samples_left_q - SL_WIDTH'(1);
                armed_d        = 1'b1;
                state_d        = (samples_left_q == SL_WIDTH'(1)) ? S_DIVIDE : S_WAIT_RISE;
            end
            S_DIVIDE: begin
                avg_d   = COUNT_WIDTH'(acc_q >> k_q);
                state_d = S_LOAD;
            end
            S_LOAD: begin
                speed_value_d = avg_q;
                stalled_d     = 1'b0;
                state_d       = S_IDLE;
            end
            S_STALL: begin
                speed_value_d = '1;
                stalled_d     = 1'b1;
                state_d       = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Disable overrides any pending stall or load decision
        if (!bus.enable) state_d = S_IDLE;
    end

    assign bus.speed_value = speed_value_q;
    assign bus.stalled     = stalled_q;
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.speed_valid = (state_q == S_LOAD) || (state_q == S_STALL);

endmodule
`default_nettype wire
